// File: rtl/mls_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding, the {P,U} addressing-mode codes and the
// register-list width used by the sequencer and its lowest-set-bit helper.
package mls_pkg;

    localparam int LIST_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Addressing modes, encoded as {P, U} taken from IR[24:23].
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_IA = 2'b01;
    localparam logic [1:0] MODE_DB = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/lsb_index16.sv
// Lowest-set-bit finder for a 16-bit register list.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   vec   in   16  register list
//   idx   out  4   index of the lowest set bit (0 when vec is empty)
//   mask  out  16  one-hot mask of that bit (all zero when vec is empty)
module lsb_index16
    import mls_pkg::*;
(
    input  logic [LIST_W-1:0] vec,
    output logic [3:0]        idx,
    output logic [LIST_W-1:0] mask
);

    always_comb begin
        // Two's-complement trick isolates the lowest set bit.
        mask = vec & (~vec + LIST_W'(1));
        idx  = 4'd0;
        // Scan from the top so the last hit is the lowest set bit.
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/mls_sequencer.sv
// LDM/STM register-list sequencer returning MLS0/MLS1 status to the control unit.
// Latency: 1 cycle from LoadCNT/CST edge to updated outputs.
// Backpressure: none; LoadCNT/CST are single-cycle strobes, CST outside ACTIVE is dropped.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   IR                instruction: [24]=P [23]=U [21]=W [20]=L [15:0]=register list
//   BASE              base register value, sampled with LoadCNT
//   LoadCNT, CST      load list / step to next register (LoadCNT wins when both high)
//   REG_SEL, ADDR     lowest pending register and its memory address
//   WB_ADDR           final base value for writeback
//   WB_EN, IS_LOAD    latched W and L bits
//   MLS0, MLS1        sequence done / current register is the last one
// Optional build macro MLS_EMPTY_LIST_EN: an empty list transfers R15 only and
// moves the base as if 16 registers were listed.
module mls_sequencer
    import mls_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STEP_BYTES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] BASE,
    input  logic              LoadCNT,
    input  logic              CST,
    output logic [3:0]        REG_SEL,
    output logic [ADDR_W-1:0] ADDR,
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic              WB_EN,
    output logic              IS_LOAD,
    output logic              MLS0,
    output logic              MLS1
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STEP_BYTES);

    state_t              state;
    state_t              state_nxt;
    logic [LIST_W-1:0]   pending;
    logic [LIST_W-1:0]   pending_cleared;
    logic [LIST_W-1:0]   lsb_mask;
    logic [3:0]          lsb_idx;

    logic [LIST_W-1:0]   ld_list;
    logic [4:0]          ld_cnt;
    logic [ADDR_W-1:0]   span;
    logic [ADDR_W-1:0]   addr0;
    logic [ADDR_W-1:0]   wb_calc;

    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic                wb_en_q;
    logic                is_load_q;

    // IR fields this block never looks at.
    logic unused_ir;
    assign unused_ir = ^{IR[31:25], IR[22], IR[19:16]};

    lsb_index16 u_lsb (
        .vec  (pending),
        .idx  (lsb_idx),
        .mask (lsb_mask)
    );

    assign pending_cleared = pending & ~lsb_mask;

    // Load-time decode: effective list, register count and the two addresses.
    always_comb begin
        ld_list = IR[LIST_W-1:0];
        ld_cnt  = 5'd0;
        for (int i = 0; i < LIST_W; i++) begin
            ld_cnt = ld_cnt + 5'(IR[i]);
        end
`ifdef MLS_EMPTY_LIST_EN
        // Empty list behaves as {R15} but moves the base by a full 16 slots.
        if (IR[LIST_W-1:0] == '0) begin
            ld_list = LIST_W'(1) << 15;
            ld_cnt  = 5'd16;
        end
`endif
        span = STEP * ADDR_W'(ld_cnt);

        // Registers always go out at ascending addresses, so decrementing
        // modes start at the bottom of the block.
        case ({IR[24], IR[23]})
            MODE_IA: addr0 = BASE;
            MODE_IB: addr0 = BASE + STEP;
            MODE_DA: addr0 = BASE - span + STEP;
            default: addr0 = BASE - span;
        endcase

        wb_calc = IR[23] ? (BASE + span) : (BASE - span);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        MLS0      = 1'b0;
        MLS1      = 1'b0;

        if (LoadCNT) begin
            state_nxt = (ld_list != '0) ? ST_ACTIVE : ST_DONE;
        end else if (CST && (state == ST_ACTIVE) && (pending_cleared == '0)) begin
            state_nxt = ST_DONE;
        end

        MLS0 = (state == ST_DONE);
        // Exactly one bit set; pending is never zero while ACTIVE.
        MLS1 = (state == ST_ACTIVE) && (pending != '0) &&
               ((pending & (pending - LIST_W'(1))) == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending   <= '0;
            addr_q    <= '0;
            wb_addr_q <= '0;
            wb_en_q   <= 1'b0;
            is_load_q <= 1'b0;
        end else if (LoadCNT) begin
            pending   <= ld_list;
            addr_q    <= addr0;
            wb_addr_q <= wb_calc;
            wb_en_q   <= IR[21];
            is_load_q <= IR[20];
        end else if (CST && (state == ST_ACTIVE)) begin
            pending   <= pending_cleared;
            addr_q    <= addr_q + STEP;
        end
    end

    assign REG_SEL = lsb_idx;
    assign ADDR    = addr_q;
    assign WB_ADDR = wb_addr_q;
    assign WB_EN   = wb_en_q;
    assign IS_LOAD = is_load_q;

endmodule
